// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI memory responder.
package spi_slave_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  // Wide enough for the dummy-phase count as well as bit counts.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StWdata,
    StRdata,
    StIgnore
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for asynchronous SPI pins with rise/fall detection on one of them.
module spi_sync_edge #(
  parameter int unsigned      Width        = 1,
  parameter int unsigned      Stages       = 2,
  parameter logic [Width-1:0] DataResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             edge_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             rise_o,
  output logic             fall_o
);

  // Bit 0 carries the edge-detected signal, upper bits the sync-only data.
  logic [Width:0] stage_q [Stages];
  logic [Width:0] sync_s;
  logic           edge_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Stages; i++) begin
        stage_q[i] <= {DataResetVal, 1'b0};
      end
      edge_q <= 1'b0;
    end else begin
      stage_q[0] <= {data_i, edge_i};
      for (int i = 1; i < Stages; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      edge_q <= sync_s[0];
    end
  end

  assign sync_s = stage_q[Stages-1];
  assign data_o = sync_s[Width:1];
  assign rise_o = sync_s[0] & ~edge_q;
  assign fall_o = ~sync_s[0] & edge_q;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 responder translating serial write/read commands into a req/gnt memory port.
module spi_slave_mem
  import spi_slave_pkg::*;
#(
  parameter int unsigned DUMMY_CYCLES = 34,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_en_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  logic [1:0] sync_s;
  logic       cs_s, sdi_s, sclk_rise, sclk_fall;

  // CS resets to its idle (high) level so reset does not look like a frame start.
  spi_sync_edge #(
    .Width       (2),
    .Stages      (SYNC_STAGES),
    .DataResetVal(2'b01)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .edge_i(spi_sclk_i),
    .data_i({spi_sdi_i, spi_cs_i}),
    .data_o(sync_s),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  assign cs_s  = sync_s[0];
  assign sdi_s = sync_s[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [30:0]      rx_q, rx_d;
  logic [31:0]      tx_q, tx_d;
  logic             sdo_q, sdo_d;
  logic             is_wr_q, is_wr_d;
  logic [31:0]      addr_q, addr_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rd_wait_q, rd_wait_d;
  logic             rd_have_q, rd_have_d;
  logic             err_q, err_d;

  logic        issue, issue_we;
  logic [31:0] issue_addr, issue_wdata;
  logic [31:0] shift_in;

  assign shift_in = {rx_q, sdi_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    sdo_d       = sdo_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    req_d       = req_q;
    we_d        = we_q;
    maddr_d     = maddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rd_wait_d   = rd_wait_q;
    rd_have_d   = rd_have_q;
    err_d       = 1'b0;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;

    if (req_q && mem_gnt_i) begin
      req_d = 1'b0;
    end
    if (rd_wait_q && mem_rvalid_i) begin
      rdata_d   = mem_rdata_i;
      rd_wait_d = 1'b0;
      rd_have_d = 1'b1;
    end

    if (cs_s) begin
      state_d = StIdle;
      cnt_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
      sdo_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCmd;
          cnt_d   = CNT_W'(7);
        end
        StCmd: begin
          if (sclk_rise) begin
            rx_d = shift_in[30:0];
            if (cnt_q == '0) begin
              if (shift_in[7:0] == CMD_WRITE || shift_in[7:0] == CMD_READ) begin
                state_d = StAddr;
                cnt_d   = CNT_W'(31);
                is_wr_d = (shift_in[7:0] == CMD_WRITE);
              end else begin
                state_d = StIgnore;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StAddr: begin
          if (sclk_rise) begin
            rx_d = shift_in[30:0];
            if (cnt_q == '0) begin
              addr_d = shift_in;
              if (is_wr_q) begin
                state_d = StWdata;
                cnt_d   = CNT_W'(31);
              end else begin
                issue      = 1'b1;
                issue_addr = shift_in;
                state_d    = StDummy;
                cnt_d      = CNT_W'(DUMMY_CYCLES - 1);
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StDummy: begin
          if (sclk_rise) begin
            if (cnt_q == '0) begin
              state_d = StRdata;
              cnt_d   = CNT_W'(31);
              // Data arriving in the very cycle of the last dummy rise is still usable.
              if (rd_have_q) begin
                tx_d      = rdata_q;
                rd_have_d = 1'b0;
              end else if (rd_wait_q && mem_rvalid_i) begin
                tx_d      = mem_rdata_i;
                rd_have_d = 1'b0;
              end else begin
                tx_d  = '0;
                err_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StRdata: begin
          if (sclk_fall) begin
            sdo_d = tx_q[31];
            tx_d  = {tx_q[30:0], 1'b0};
          end
          if (sclk_rise) begin
            if (cnt_q == '0) begin
              state_d = StCmd;
              cnt_d   = CNT_W'(7);
              sdo_d   = 1'b0;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StWdata: begin
          if (sclk_rise) begin
            rx_d = shift_in[30:0];
            if (cnt_q == '0) begin
              issue       = 1'b1;
              issue_we    = 1'b1;
              issue_addr  = addr_q;
              issue_wdata = shift_in;
              state_d     = StCmd;
              cnt_d       = CNT_W'(7);
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StIgnore: begin
          state_d = StIgnore;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // A still-outstanding request wins; the new one is dropped and flagged.
    if (issue) begin
      if (req_q && !mem_gnt_i) begin
        err_d = 1'b1;
      end else begin
        req_d   = 1'b1;
        we_d    = issue_we;
        maddr_d = issue_addr;
        if (issue_we) begin
          wdata_d = issue_wdata;
        end else begin
          rd_wait_d = 1'b1;
          rd_have_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      sdo_q     <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_wait_q <= 1'b0;
      rd_have_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      sdo_q     <= sdo_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_wait_q <= rd_wait_d;
      rd_have_q <= rd_have_d;
      err_q     <= err_d;
    end
  end

  assign spi_sdo_o    = sdo_q;
  assign spi_sdo_en_o = (state_q == StRdata);
  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wdata_o  = wdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed bench: SPI master stimulus, RAM-like memory model and request/read-data scoreboard.
module tb_spi_slave_mem;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        spi_sclk_i, spi_cs_i, spi_sdi_i;
  logic        spi_sdo_o, spi_sdo_en_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  spi_slave_mem #(
    .DUMMY_CYCLES(34),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .spi_sclk_i  (spi_sclk_i),
    .spi_cs_i    (spi_cs_i),
    .spi_sdi_i   (spi_sdi_i),
    .spi_sdo_o   (spi_sdo_o),
    .spi_sdo_en_o(spi_sdo_en_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ram[logic [31:0]];

  int n_cmp = 0, n_err = 0;
  int gnt_delay = 2, rv_delay = 3, req_age = 0, n_gnt = 0, n_stray = 0;
  int err_total = 0, err_double = 0;
  logic err_prev = 1'b0;
  logic rv_pend = 1'b0;
  int rv_wait = 0;
  logic [31:0] rv_data = '0;
  logic snap_we;
  logic [31:0] snap_addr, snap_wdata;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode-0 master: sdi set while sclk low, sdo sampled just before each rise.
  task automatic xfer(input logic [255:0] bits, input int n,
                      output logic [255:0] so, output logic [255:0] en);
    so = '0;
    en = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi_i = bits[i];
      repeat (4) @(posedge clk_i);
      #1;
      so = {so[254:0], spi_sdo_o};
      en = {en[254:0], spi_sdo_en_o};
      spi_sclk_i = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      spi_sclk_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic cs_high();
    repeat (4) @(posedge clk_i);
    #1;
    spi_cs_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (err_o) err_total++;
    if (err_o && err_prev) err_double++;
    err_prev = err_o;
  end

  // Memory model: grants after gnt_delay cycles, returns read data rv_delay cycles later.
  initial begin
    req_t e;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rv_pend) begin
        if (rv_wait == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rv_data;
          rv_pend      = 1'b0;
        end else begin
          rv_wait--;
        end
      end
      if (!mem_req_o) begin
        req_age = 0;
      end else begin
        if (req_age == 0) begin
          snap_we    = mem_we_o;
          snap_addr  = mem_addr_o;
          snap_wdata = mem_wdata_o;
        end
        if (req_age >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          req_age   = 0;
          n_gnt++;
          check("req_stable", 256'({mem_we_o, mem_addr_o, mem_wdata_o}),
                256'({snap_we, snap_addr, snap_wdata}));
          if (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            check("req_we", 256'(mem_we_o), 256'(e.we));
            check("req_addr", 256'(mem_addr_o), 256'(e.addr));
            if (e.we) begin
              check("req_wdata", 256'(mem_wdata_o), 256'(e.wdata));
              ram[mem_addr_o] = mem_wdata_o;
            end else begin
              rv_data = ram.exists(mem_addr_o) ? ram[mem_addr_o] : '0;
              if (rv_delay == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rv_data;
              end else begin
                rv_pend = 1'b1;
                rv_wait = rv_delay - 1;
              end
            end
          end else begin
            n_stray++;
          end
        end else begin
          req_age++;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] so_v, en_v;
    int exp_err, g0;
    exp_err    = 0;
    rst_ni     = 1'b0;
    spi_sclk_i = 1'b0;
    spi_cs_i   = 1'b1;
    spi_sdi_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs", 256'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                                 spi_sdo_o, spi_sdo_en_o, err_o}), '0);
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    // Single write
    exp_req.push_back('{we: 1'b1, addr: 32'h64, wdata: 32'h64});
    cs_low();
    xfer(256'({8'h02, 32'h64, 32'h64}), 72, so_v, en_v);
    cs_high();
    check("t1_req_done", 256'(exp_req.size()), '0);
    check("t1_sdo_en", en_v, '0);
    check("t1_err", 256'(err_total), 256'(exp_err));

    // Single read, data returned 3 cycles after grant
    ram[32'h64] = 32'hDEADBEEF;
    exp_req.push_back('{we: 1'b0, addr: 32'h64, wdata: 32'h0});
    exp_rd.push_back(32'hDEADBEEF);
    cs_low();
    xfer(256'({8'h0B, 32'h64, 66'd0}), 106, so_v, en_v);
    cs_high();
    check("t2_rdata", so_v, 256'(exp_rd.pop_front()));
    check("t2_sdo_en_window", en_v, 256'({32{1'b1}}));
    check("t2_sdo_en_idle", 256'(spi_sdo_en_o), '0);
    check("t2_req_done", 256'(exp_req.size()), '0);

    // Write then read in one CS window
    exp_req.push_back('{we: 1'b1, addr: 32'h64, wdata: 32'h64});
    exp_req.push_back('{we: 1'b0, addr: 32'h64, wdata: 32'h0});
    exp_rd.push_back(32'h64);
    cs_low();
    xfer(256'({8'h02, 32'h64, 32'h64}), 72, so_v, en_v);
    xfer(256'({8'h0B, 32'h64, 66'd0}), 106, so_v, en_v);
    cs_high();
    check("t3_rdata", so_v, 256'(exp_rd.pop_front()));
    check("t3_req_done", 256'(exp_req.size()), '0);

    // Read data withheld past the dummy phase
    rv_delay = 400;
    exp_req.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    exp_rd.push_back(32'h0);
    exp_err++;
    cs_low();
    xfer(256'({8'h0B, 32'h200, 66'd0}), 106, so_v, en_v);
    cs_high();
    rv_delay = 3;
    check("t4_rdata_zero", so_v, 256'(exp_rd.pop_front()));
    check("t4_err_pulse", 256'(err_total), 256'(exp_err));

    // Aborted write frame, then a full write
    g0 = n_gnt;
    cs_low();
    xfer(256'({8'h02, 20'hABCDE}), 28, so_v, en_v);
    cs_high();
    check("t5_abort_no_req", 256'(n_gnt), 256'(g0));
    exp_req.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hA5A5A5A5});
    cs_low();
    xfer(256'({8'h02, 32'h10, 32'hA5A5A5A5}), 72, so_v, en_v);
    cs_high();
    check("t5_req_done", 256'(exp_req.size()), '0);
    check("t5_ram", 256'(ram[32'h10]), 256'(32'hA5A5A5A5));

    // Unknown command is ignored for the rest of the frame
    g0 = n_gnt;
    cs_low();
    xfer(256'({8'h05, 72'hF0F0123456789ABCDE}), 80, so_v, en_v);
    cs_high();
    check("t6_no_req", 256'(n_gnt), 256'(g0));
    check("t6_sdo_en", en_v, '0);
    check("t6_sdo", so_v, '0);

    // Reset during WDATA with an ungranted request outstanding
    gnt_delay = 1000000;
    exp_req.push_back('{we: 1'b1, addr: 32'h30, wdata: 32'h11112222});
    cs_low();
    xfer(256'({8'h02, 32'h30, 32'h11112222}), 72, so_v, en_v);
    xfer(256'({8'h02, 32'h40, 16'hBEEF}), 56, so_v, en_v);
    check("t7_req_held", 256'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
          256'({1'b1, 1'b1, 32'h30, 32'h11112222}));
    #2;
    rst_ni = 1'b0;
    #1;
    check("t7_reset_outputs", 256'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                                    spi_sdo_o, spi_sdo_en_o, err_o}), '0);
    exp_req.delete();
    spi_cs_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni    = 1'b1;
    gnt_delay = 2;
    repeat (5) @(posedge clk_i);
    #1;
    exp_req.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h12345678});
    exp_req.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    exp_rd.push_back(32'h12345678);
    cs_low();
    xfer(256'({8'h02, 32'h20, 32'h12345678}), 72, so_v, en_v);
    xfer(256'({8'h0B, 32'h20, 66'd0}), 106, so_v, en_v);
    cs_high();
    check("t7_rdata_after_reset", so_v, 256'(exp_rd.pop_front()));
    check("t7_req_done", 256'(exp_req.size()), '0);

    check("stray_req", 256'(n_stray), '0);
    check("err_single_cycle", 256'(err_double), '0);
    check("err_total", 256'(err_total), 256'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
